// File: rtl/nor_scan_if.sv
// Bundle between nor_scan_ctrl and its surroundings: the control side (start/stop,
// results) and the function under evaluation (vec out, f_in back).
//   slave  : modport used by nor_scan_ctrl
//   master : modport used by the control logic / FUE model driving it
// N_IN sets the FUE input count; the truth table is 2**N_IN bits wide.
interface nor_scan_if #(
  parameter int unsigned N_IN = 4
);
  logic                 start;
  logic                 stop;
  logic [N_IN-1:0]      vec;
  logic                 f_in;
  logic [2**N_IN-1:0]   expected;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   table_out;
  logic [N_IN:0]        mismatch_cnt;
  logic [N_IN-1:0]      first_bad;
  logic                 pass;

  modport slave (
    input  start, stop, f_in, expected,
    output vec, busy, done, table_out, mismatch_cnt, first_bad, pass
  );

  modport master (
    output start, stop, f_in, expected,
    input  vec, busy, done, table_out, mismatch_cnt, first_bad, pass
  );
endinterface

// File: rtl/nor_scan_ctrl.sv
// Truth-table scanner: steps vec through 0 .. 2**N_IN-1, holds each value for SETTLE+1
// cycles, samples f_in on the last edge into table_out[vec], then pulses done.
// Ports:
//   clk_i  : clock, all state on rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : nor_scan_if.slave (start/stop in, vec out, f_in in, expected in,
//            busy/done/table_out/mismatch_cnt/first_bad/pass out)
// Build option: define SCAN_COMPARE_EN to compare the captured table against
// bus.expected (mismatch_cnt, first_bad, pass = no mismatches). Without it,
// mismatch_cnt/first_bad are 0 and pass pulses with done.
module nor_scan_ctrl #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  nor_scan_if.slave  bus
);

  localparam int unsigned TabW = 2**N_IN;
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StSample, StFinish} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TabW-1:0]   table_q, table_d;
  logic              busy, done;

`ifdef SCAN_COMPARE_EN
  logic [N_IN:0]     mm_q, mm_d;
  logic [N_IN-1:0]   fb_q, fb_d;
  logic              pass_q, pass_d;
`endif

  // With SETTLE == 0 there is no wait phase: every cycle is a sample.
  localparam state_e StAfterLoad = (SETTLE == 0) ? StSample : StWait;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    busy    = 1'b0;
    done    = 1'b0;
`ifdef SCAN_COMPARE_EN
    mm_d    = mm_q;
    fb_d    = fb_q;
    pass_d  = pass_q;
`endif
    unique case (state_q)
      StIdle: begin
        // stop has priority over start
        if (bus.start && !bus.stop) begin
          table_d = '0;
          vec_d   = '0;
          cnt_d   = CntW'(SETTLE);
          state_d = StAfterLoad;
`ifdef SCAN_COMPARE_EN
          mm_d    = '0;
          fb_d    = '0;
          pass_d  = 1'b0;
`endif
        end
      end
      StWait: begin
        busy = 1'b1;
        if (bus.stop) begin
          state_d = StIdle;
          vec_d   = '0;
        end else if (cnt_q <= CntW'(1)) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSample: begin
        busy = 1'b1;
        if (bus.stop) begin
          // abort wins over the sample on this edge; partial results are kept
          state_d = StIdle;
          vec_d   = '0;
        end else begin
          table_d[vec_q] = bus.f_in;
`ifdef SCAN_COMPARE_EN
          if (bus.f_in != bus.expected[vec_q]) begin
            mm_d = mm_q + (N_IN + 1)'(1);
            if (mm_q == '0) fb_d = vec_q;
          end
`endif
          if (&vec_q) begin
            state_d = StFinish;
`ifdef SCAN_COMPARE_EN
            // registered here so pass is already valid in the done cycle
            pass_d = (mm_d == '0);
`endif
          end else begin
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = CntW'(SETTLE);
            state_d = StAfterLoad;
          end
        end
      end
      StFinish: begin
        // stop and start are both ignored here
        busy    = 1'b1;
        done    = 1'b1;
        vec_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
`ifdef SCAN_COMPARE_EN
      mm_q    <= '0;
      fb_q    <= '0;
      pass_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
`ifdef SCAN_COMPARE_EN
      mm_q    <= mm_d;
      fb_q    <= fb_d;
      pass_q  <= pass_d;
`endif
    end
  end

  assign bus.vec       = vec_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.table_out = table_q;
`ifdef SCAN_COMPARE_EN
  assign bus.mismatch_cnt = mm_q;
  assign bus.first_bad    = fb_q;
  assign bus.pass         = pass_q;
`else
  assign bus.mismatch_cnt = '0;
  assign bus.first_bad    = '0;
  assign bus.pass         = done;
`endif

endmodule

// File: tb/tb_nor_scan_ctrl.sv
// Bench for nor_scan_ctrl: instance 0 uses SETTLE=1, instance 1 uses SETTLE=0.
// The FUE is modelled as a lookup of a truth table held in tt_r[] indexed by vec.
module tb_nor_scan_ctrl;

`ifdef SCAN_COMPARE_EN
  localparam bit CmpEn = 1'b1;
`else
  localparam bit CmpEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nor_scan_if #(.N_IN(4)) if_a ();
  nor_scan_if #(.N_IN(4)) if_b ();

  nor_scan_ctrl #(.N_IN(4), .SETTLE(1)) u_a (.clk_i(clk), .rst_i(rst), .bus(if_a.slave));
  nor_scan_ctrl #(.N_IN(4), .SETTLE(0)) u_b (.clk_i(clk), .rst_i(rst), .bus(if_b.slave));

  logic        start_r [2];
  logic        stop_r  [2];
  logic [15:0] tt_r    [2];
  logic [15:0] exp_r   [2];

  logic        busy_w [2];
  logic        done_w [2];
  logic        pass_w [2];
  logic [3:0]  vec_w  [2];
  logic [3:0]  fb_w   [2];
  logic [4:0]  mm_w   [2];
  logic [15:0] tab_w  [2];

  assign if_a.start    = start_r[0];
  assign if_a.stop     = stop_r[0];
  assign if_a.expected = exp_r[0];
  assign if_a.f_in     = tt_r[0][if_a.vec];
  assign if_b.start    = start_r[1];
  assign if_b.stop     = stop_r[1];
  assign if_b.expected = exp_r[1];
  assign if_b.f_in     = tt_r[1][if_b.vec];

  assign busy_w[0] = if_a.busy;      assign busy_w[1] = if_b.busy;
  assign done_w[0] = if_a.done;      assign done_w[1] = if_b.done;
  assign pass_w[0] = if_a.pass;      assign pass_w[1] = if_b.pass;
  assign vec_w[0]  = if_a.vec;       assign vec_w[1]  = if_b.vec;
  assign fb_w[0]   = if_a.first_bad; assign fb_w[1]   = if_b.first_bad;
  assign mm_w[0]   = if_a.mismatch_cnt; assign mm_w[1] = if_b.mismatch_cnt;
  assign tab_w[0]  = if_a.table_out; assign tab_w[1]  = if_b.table_out;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  // Reference: count of differing bits and the lowest differing index.
  function automatic void model(input logic [15:0] tt, input logic [15:0] ex,
                                output int mm, output int fb);
    mm = 0;
    fb = 0;
    for (int i = 0; i < 16; i++) begin
      if (tt[i] != ex[i]) begin
        if (mm == 0) fb = i;
        mm++;
      end
    end
  endfunction

  // Full scan on instance s; mm/fb are the compare-enabled expectations.
  task automatic run_scan(input int s, input logic [15:0] tt, input logic [15:0] ex,
                          input int mm, input int fb, input bit repulse, input string nm);
    int  settle   = (s == 0) ? 1 : 0;
    int  lat      = 16 * (settle + 1) + 1;
    int  cyc      = 0;
    int  done_cyc = 0;
    int  busy_cnt = 0;
    bit  vec_ok   = 1'b1;
    int  e_mm     = CmpEn ? mm : 0;
    int  e_fb     = CmpEn ? fb : 0;
    bit  e_pass   = CmpEn ? (mm == 0) : 1'b1;
    bit  e_pass2  = CmpEn ? (mm == 0) : 1'b0;
    tt_r[s]  = tt;
    exp_r[s] = ex;
    @(negedge clk);
    start_r[s] = 1'b1;
    @(posedge clk);
    #1 start_r[s] = 1'b0;
    while (done_cyc == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (repulse && cyc == 10) start_r[s] = 1'b1;
      if (repulse && cyc == 11) start_r[s] = 1'b0;
      if (cyc < lat && vec_w[s] !== 4'((cyc - 1) / (settle + 1))) vec_ok = 1'b0;
      if (done_w[s] === 1'b1) begin
        done_cyc = cyc;
        check({nm, ".busy_at_done"}, 32'(busy_w[s]), 32'd1);
        check({nm, ".table"}, 32'(tab_w[s]), 32'(tt));
        check({nm, ".mismatch_cnt"}, 32'(mm_w[s]), 32'(e_mm));
        check({nm, ".first_bad"}, 32'(fb_w[s]), 32'(e_fb));
        check({nm, ".pass_at_done"}, 32'(pass_w[s]), 32'(e_pass));
      end else if (busy_w[s] === 1'b1) begin
        busy_cnt++;
      end
    end
    start_r[s] = 1'b0;
    check({nm, ".latency"}, 32'(done_cyc), 32'(lat));
    check({nm, ".busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
    check({nm, ".vec_sequence"}, 32'(vec_ok), 32'd1);
    @(negedge clk);
    check({nm, ".done_after"}, 32'(done_w[s]), 32'd0);
    check({nm, ".busy_after"}, 32'(busy_w[s]), 32'd0);
    check({nm, ".vec_after"}, 32'(vec_w[s]), 32'd0);
    check({nm, ".table_hold"}, 32'(tab_w[s]), 32'(tt));
    check({nm, ".pass_after"}, 32'(pass_w[s]), 32'(e_pass2));
  endtask

  typedef struct {
    int          sel;
    logic [15:0] tt;
    logic [15:0] ex;
    int          mm;
    int          fb;
  } vec_t;

  vec_t tbl [5];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int   mm;
    int   fb;
    int   cyc;
    bit   seen_done;
    bit   ok;
    logic [15:0] tt;
    logic [15:0] ex;

    // s = X & Y is 16'hF000; s = Z is 16'hAAAA
    tbl[0] = '{sel: 0, tt: 16'hF000, ex: 16'hF000, mm: 0,  fb: 0};
    tbl[1] = '{sel: 0, tt: 16'hF000, ex: 16'hF001, mm: 1,  fb: 0};
    tbl[2] = '{sel: 0, tt: 16'hF000, ex: 16'hF208, mm: 2,  fb: 3};
    tbl[3] = '{sel: 1, tt: 16'hAAAA, ex: 16'hAAAA, mm: 0,  fb: 0};
    tbl[4] = '{sel: 0, tt: 16'hAAAA, ex: 16'h5555, mm: 16, fb: 0};

    for (int s = 0; s < 2; s++) begin
      start_r[s] = 1'b0;
      stop_r[s]  = 1'b0;
      tt_r[s]    = 16'h0;
      exp_r[s]   = 16'h0;
    end

    repeat (3) @(negedge clk);
    check("reset.busy", 32'(busy_w[0]), 32'd0);
    check("reset.vec", 32'(vec_w[0]), 32'd0);
    check("reset.table", 32'(tab_w[0]), 32'd0);
    check("reset.pass", 32'(pass_w[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_scan(tbl[i].sel, tbl[i].tt, tbl[i].ex, tbl[i].mm, tbl[i].fb, 1'b0,
               $sformatf("tbl%0d", i));

    // start re-pulsed mid-scan: latency must be unchanged
    run_scan(0, 16'hF000, 16'hF000, 0, 0, 1'b1, "repulse");

    // start and stop together in IDLE: no scan
    @(negedge clk);
    start_r[0] = 1'b1;
    stop_r[0]  = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    stop_r[0]  = 1'b0;
    ok = 1'b1;
    repeat (4) begin
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check("start_stop_idle.no_scan", 32'(ok), 32'd1);

    // stop while vec == 5
    tt_r[0]  = 16'hAAAA;
    exp_r[0] = 16'hAAAA;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk);
    #1 start_r[0] = 1'b0;
    cyc = 0;
    seen_done = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (done_w[0] === 1'b1) seen_done = 1'b1;
    end while (vec_w[0] !== 4'd5 && cyc < 100);
    check("stop.reached_vec5", 32'(vec_w[0]), 32'd5);
    stop_r[0] = 1'b1;
    @(negedge clk);
    stop_r[0] = 1'b0;
    if (done_w[0] === 1'b1) seen_done = 1'b1;
    check("stop.busy", 32'(busy_w[0]), 32'd0);
    check("stop.vec", 32'(vec_w[0]), 32'd0);
    check("stop.no_done", 32'(seen_done), 32'd0);
    check("stop.partial_table", 32'(tab_w[0]), 32'h000A);
    check("stop.pass", 32'(pass_w[0]), 32'd0);
    run_scan(0, 16'hAAAA, 16'hAAAA, 0, 0, 1'b0, "after_stop");

    // reset between edges at cycle 10 of a scan
    tt_r[0] = 16'hAAAA;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk);
    #1 start_r[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset.busy", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset.busy", 32'(busy_w[0]), 32'd0);
    check("async_reset.done", 32'(done_w[0]), 32'd0);
    check("async_reset.vec", 32'(vec_w[0]), 32'd0);
    check("async_reset.table", 32'(tab_w[0]), 32'd0);
    check("async_reset.mm", 32'(mm_w[0]), 32'd0);
    check("async_reset.fb", 32'(fb_w[0]), 32'd0);
    check("async_reset.pass", 32'(pass_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_scan(0, 16'hF000, 16'hF000, 0, 0, 1'b0, "after_reset");

    // random FUEs against the reference model
    for (int r = 0; r < 12; r++) begin
      int s = int'($urandom_range(1, 0));
      tt = 16'($urandom);
      ex = ($urandom_range(3, 0) == 0) ? tt : (tt ^ 16'($urandom));
      model(tt, ex, mm, fb);
      run_scan(s, tt, ex, mm, fb, 1'b0, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
